alu_cmd_engine: RTL and testbench
=================================

// Module: alu_cmd_engine
// PURPOSE
//  Initiator side of the 2-bit ALU operand interface (ain/bin/sel -> zout).
//  Accepts operand commands over a valid/ready stream and drives registered operands into an
//  external combinational ALU. Holds them SETTLE_CYC cycles, then samples zout.
//  Queues results on a valid/ready response stream and folds every result into a MISR
//  signature that test logic reads out.
// PARAMETERS
//  W          2        operand/result width (matches ALU port width)
//  SETTLE_CYC 1        cycles operands are held before zout is sampled; legal 1..15
//  DEPTH      4        response FIFO entries; power of 2, >=2
//  SIG_W      16       MISR width
//  POLY       16'h1021 MISR feedback polynomial (SIG_W bits)
// PORTS
//  clk        in  1      clock, rising edge
//  rst        in  1      synchronous reset, active-high
//  cmd_valid  in  1      command present
//  cmd_ready  out 1      command accepted when valid&ready at clk edge
//  cmd_ain    in  W      operand A
//  cmd_bin    in  W      operand B
//  cmd_sel    in  1      ALU op select
//  alu_ain    out W      registered operand A to ALU
//  alu_bin    out W      registered operand B to ALU
//  alu_sel    out 1      registered select to ALU
//  alu_zout   in  W      ALU result (combinational from alu_* outputs)
//  rsp_valid  out 1      FIFO non-empty
//  rsp_ready  in  1      consumer pops on valid&ready
//  rsp_data   out W      FIFO head result
//  sig_clear  in  1      synchronous MISR clear
//  sig_out    out SIG_W  MISR state
//  busy       out 1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, alu_ain/alu_bin/alu_sel=0, FIFO empty, sig_out=0, settle cnt=0.
//    Also rsp_valid=0 and busy=0. cmd_ready is forced 0 while rst=1.
//  FSM: IDLE, ISSUE.
//    IDLE: cmd_ready = (fifo_count < DEPTH).
//      On accept: load alu_* from cmd_*, cnt<=SETTLE_CYC-1, go to ISSUE.
//    ISSUE: cmd_ready=0 and alu_* held stable. Decrement cnt each cycle.
//      At the edge where cnt==0: push alu_zout into FIFO, update MISR, return to IDLE.
//  Latency: accept at edge N, capture at edge N+SETTLE_CYC. rsp_valid rises after that edge if FIFO was empty.
//    Throughput: 1 command per SETTLE_CYC+1 cycles.
//  One command is in flight at most, and accept requires count<DEPTH, so push never overflows.
//    Push and pop in the same cycle: count is unchanged and data order is preserved.
//  alu_* keep the last issued value while IDLE and do not return to 0.
//  MISR on capture: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zext(alu_zout).
//    If sig_clear and capture occur in the same cycle, clear wins: sig=0, and the result is still pushed to the FIFO.
//  Pop while empty has no effect. rsp_data is don't-care when rsp_valid=0.
//  rst mid-ISSUE: the in-flight command is dropped with no push. FIFO is flushed and sig is cleared.
//  Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
// STRUCTURE
//  Package alu_cmd_pkg: state enum {IDLE, ISSUE}, default POLY constant, W default.
//  Sub-module alu_rsp_fifo (W, DEPTH): sync FIFO with push/pop/count/full/empty.
//    It resets synchronously on rst.
//  Top level holds the FSM, settle counter, operand registers and MISR.
// TESTING
//  Bench ALU stub: zout = sel ? (ain & bin) : (ain + bin) mod 4.
//  1. Reset, then cmd {a=1, b=2, sel=0}, SETTLE_CYC=1 -> alu_ain=1, alu_bin=2 after the accept edge.
//     rsp_valid rises 1 edge later with rsp_data=3. busy=1 for exactly 1 cycle.
//  2. rsp_ready=0, issue 5 cmds -> 4 accepted, cmd_ready stays 0 afterwards.
//     One pop -> 5th cmd accepted. Results drain in order.
//  3. sig_clear, then results 2'b10 and 2'b11 -> sig_out=0x0002, then 0x0007.
//  4. sig_clear asserted in the capture cycle -> sig_out=0 and the FIFO still receives the result.
//  5. SETTLE_CYC=3: alu_* stable for 3 cycles. Capture on the 3rd edge after accept. cmd_ready=0 throughout.
//  6. Assert rst during ISSUE with 2 results queued -> next cycle rsp_valid=0, sig_out=0, busy=0.
//     alu_*=0, cmd_ready=1 after rst drops.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared types and defaults for the ALU command engine and its response FIFO.
package alu_cmd_pkg;
    localparam int          ALU_W     = 2;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;
endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; pointers wrap naturally because DEPTH is a power of two.
module alu_rsp_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_head    = r_mem[r_rd];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr] <= i_push_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok)
                r_wr <= r_wr + AW'(1);
            if (w_pop_ok)
                r_rd <= r_rd + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_engine.sv
// Drives registered operands into an external ALU, samples the result after a settle window,
// queues it for the consumer and folds it into a MISR signature.
module alu_cmd_engine
    import alu_cmd_pkg::*;
#(
    parameter int               W          = ALU_W,
    parameter int               SETTLE_CYC = 1,
    parameter int               DEPTH      = 4,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(MISR_POLY)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [W-1:0]     i_cmd_ain,
    input  logic [W-1:0]     i_cmd_bin,
    input  logic             i_cmd_sel,
    output logic [W-1:0]     o_alu_ain,
    output logic [W-1:0]     o_alu_bin,
    output logic             o_alu_sel,
    input  logic [W-1:0]     i_alu_zout,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [W-1:0]     o_rsp_data,
    input  logic             i_sig_clear,
    output logic [SIG_W-1:0] o_sig_out,
    output logic             o_busy
);
    localparam int AW = $clog2(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [W-1:0]     r_ain;
    logic [W-1:0]     r_bin;
    logic             r_sel;
    logic [SIG_W-1:0] r_sig;
    logic             w_accept;
    logic             w_capture;
    logic             w_cmd_ready;
    logic [AW:0]      w_count;
    logic             w_full;
    logic             w_empty;

    assign w_capture = (r_state == ISSUE) && (r_cnt == 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = ~i_rst & (w_count < (AW+1)'(DEPTH));
                w_accept    = i_cmd_valid & w_cmd_ready;
                if (w_accept)
                    w_next = ISSUE;
            end
            ISSUE: begin
                if (r_cnt == 4'd0)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operands stay at their last issued value while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ain <= '0;
            r_bin <= '0;
            r_sel <= 1'b0;
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_ain <= i_cmd_ain;
            r_bin <= i_cmd_bin;
            r_sel <= i_cmd_sel;
            r_cnt <= 4'(SETTLE_CYC - 1);
        end else if (r_state == ISSUE && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Clear has priority over a same-cycle capture; the FIFO push is unaffected.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_sig_clear)
            r_sig <= '0;
        else if (w_capture)
            r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(i_alu_zout);
    end

    alu_rsp_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_capture & ~w_full),
        .i_push_data (i_alu_zout),
        .i_pop       (i_rsp_ready),
        .o_head      (o_rsp_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_cmd_ready = w_cmd_ready;
    assign o_alu_ain   = r_ain;
    assign o_alu_bin   = r_bin;
    assign o_alu_sel   = r_sel;
    assign o_rsp_valid = ~w_empty;
    assign o_sig_out   = r_sig;
    assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_alu_cmd_engine.sv
// Two engines (settle 1 and 3) share one random stimulus stream; each is checked every cycle
// against a transaction-level model, with directed literal checks pinning the model.
module tb_alu_cmd_engine;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_ain = '0;
    logic [1:0] cmd_bin = '0;
    logic       cmd_sel = 1'b0;
    logic       rsp_ready = 1'b0;
    logic       sig_clear = 1'b0;

    logic [1:0]  rdy, sel_o, rv, busy;
    logic [1:0]  aa [2];
    logic [1:0]  bb [2];
    logic [1:0]  zz [2];
    logic [1:0]  rd [2];
    logic [15:0] sg [2];

    function automatic logic [1:0] alu_f(input logic [1:0] a, input logic [1:0] b, input logic s);
        logic [1:0] r;
        r = s ? (a & b) : (a + b);
        return r;
    endfunction

    function automatic logic [15:0] misr_f(input logic [15:0] sig, input logic [1:0] res);
        logic [16:0] sh;
        sh = {sig, 1'b0};
        return sh[15:0] ^ (sh[16] ? 16'h1021 : 16'h0000) ^ {14'd0, res};
    endfunction

    function automatic int sc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    assign zz[0] = alu_f(aa[0], bb[0], sel_o[0]);
    assign zz[1] = alu_f(aa[1], bb[1], sel_o[1]);

    alu_cmd_engine #(.SETTLE_CYC(1), .DEPTH(DEPTH)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy[0]),
        .i_cmd_ain(cmd_ain), .i_cmd_bin(cmd_bin), .i_cmd_sel(cmd_sel),
        .o_alu_ain(aa[0]), .o_alu_bin(bb[0]), .o_alu_sel(sel_o[0]), .i_alu_zout(zz[0]),
        .o_rsp_valid(rv[0]), .i_rsp_ready(rsp_ready), .o_rsp_data(rd[0]),
        .i_sig_clear(sig_clear), .o_sig_out(sg[0]), .o_busy(busy[0])
    );

    alu_cmd_engine #(.SETTLE_CYC(3), .DEPTH(DEPTH)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy[1]),
        .i_cmd_ain(cmd_ain), .i_cmd_bin(cmd_bin), .i_cmd_sel(cmd_sel),
        .o_alu_ain(aa[1]), .o_alu_bin(bb[1]), .o_alu_sel(sel_o[1]), .i_alu_zout(zz[1]),
        .o_rsp_valid(rv[1]), .i_rsp_ready(rsp_ready), .o_rsp_data(rd[1]),
        .i_sig_clear(sig_clear), .o_sig_out(sg[1]), .o_busy(busy[1])
    );

    // Transaction model: one in-flight op with a countdown, a result ring, a signature.
    bit          m_inf [2];
    int          m_rem [2];
    logic [1:0]  m_a   [2];
    logic [1:0]  m_b   [2];
    logic        m_s   [2];
    logic [1:0]  m_q   [2][DEPTH];
    int          m_hd  [2];
    int          m_n   [2];
    logic [15:0] m_sig [2];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit         ready_m, cap;
        logic [1:0] res;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_inf[d] = 1'b0; m_rem[d] = 0; m_a[d] = '0; m_b[d] = '0; m_s[d] = 1'b0;
                m_hd[d] = 0; m_n[d] = 0; m_sig[d] = '0;
            end else begin
                ready_m = !m_inf[d] && (m_n[d] < DEPTH);
                cap     = m_inf[d] && (m_rem[d] == 0);
                res     = alu_f(m_a[d], m_b[d], m_s[d]);
                if (rsp_ready && m_n[d] > 0) begin
                    m_hd[d] = (m_hd[d] + 1) % DEPTH;
                    m_n[d]--;
                end
                if (cap) begin
                    m_q[d][(m_hd[d] + m_n[d]) % DEPTH] = res;
                    m_n[d]++;
                    m_inf[d] = 1'b0;
                end else if (m_inf[d]) begin
                    m_rem[d]--;
                end
                if (sig_clear)
                    m_sig[d] = '0;
                else if (cap)
                    m_sig[d] = misr_f(m_sig[d], res);
                if (cmd_valid && ready_m) begin
                    m_inf[d] = 1'b1;
                    m_rem[d] = sc(d) - 1;
                    m_a[d] = cmd_ain; m_b[d] = cmd_bin; m_s[d] = cmd_sel;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d cmd_ready", d), 32'(rdy[d]),
                    32'(!rst && !m_inf[d] && m_n[d] < DEPTH));
                chk($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(m_inf[d]));
                chk($sformatf("dut%0d alu_ain", d), 32'(aa[d]), 32'(m_a[d]));
                chk($sformatf("dut%0d alu_bin", d), 32'(bb[d]), 32'(m_b[d]));
                chk($sformatf("dut%0d alu_sel", d), 32'(sel_o[d]), 32'(m_s[d]));
                chk($sformatf("dut%0d rsp_valid", d), 32'(rv[d]), 32'(m_n[d] > 0));
                if (m_n[d] > 0)
                    chk($sformatf("dut%0d rsp_data", d), 32'(rd[d]), 32'(m_q[d][m_hd[d]]));
                chk($sformatf("dut%0d sig_out", d), 32'(sg[d]), 32'(m_sig[d]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic cmd(input logic [1:0] a, input logic [1:0] b, input logic s);
        cmd_valid = 1'b1; cmd_ain = a; cmd_bin = b; cmd_sel = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] drain_exp [4];

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset rsp_valid", 32'(rv[0]), 32'd0);
        chk("reset sig_out", 32'(sg[0]), 32'd0);
        chk("reset busy", 32'(busy[0]), 32'd0);
        chk("reset alu_ain", 32'(aa[0]), 32'd0);
        chk("cmd_ready in reset", 32'(rdy[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("cmd_ready after reset", 32'(rdy[0]), 32'd1);

        // Single command, settle 1
        cmd(2'd1, 2'd2, 1'b0);
        chk("t1 alu_ain", 32'(aa[0]), 32'd1);
        chk("t1 alu_bin", 32'(bb[0]), 32'd2);
        chk("t1 busy", 32'(busy[0]), 32'd1);
        tick();
        chk("t1 rsp_valid", 32'(rv[0]), 32'd1);
        chk("t1 rsp_data", 32'(rd[0]), 32'd3);
        chk("t1 busy drop", 32'(busy[0]), 32'd0);
        rsp_ready = 1'b1;
        repeat (4) tick();

        // MISR pins
        sig_clear = 1'b1;
        tick();
        sig_clear = 1'b0;
        chk("t3 cleared", 32'(sg[0]), 32'd0);
        cmd(2'd1, 2'd1, 1'b0);
        tick();
        chk("t3 sig 0x0002", 32'(sg[0]), 32'h0002);
        cmd(2'd1, 2'd2, 1'b0);
        tick();
        chk("t3 sig 0x0007", 32'(sg[0]), 32'h0007);

        // Clear wins over capture; result still queued
        rsp_ready = 1'b0;
        cmd(2'd3, 2'd3, 1'b1);
        sig_clear = 1'b1;
        tick();
        sig_clear = 1'b0;
        chk("t4 sig cleared", 32'(sg[0]), 32'd0);
        chk("t4 rsp_valid", 32'(rv[0]), 32'd1);
        chk("t4 rsp_data", 32'(rd[0]), 32'd3);

        // FIFO full back-pressure and ordering
        do_reset();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd(2'(k), 2'd1, 1'b0);
            tick();
        end
        cmd_valid = 1'b1; cmd_ain = 2'd0; cmd_bin = 2'd1; cmd_sel = 1'b0;
        tick();
        tick();
        chk("t2 full not ready", 32'(rdy[0]), 32'd0);
        chk("t2 full not busy", 32'(busy[0]), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t2 ready after pop", 32'(rdy[0]), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("t2 5th accepted", 32'(busy[0]), 32'd1);
        tick();
        drain_exp[0] = 2'd2; drain_exp[1] = 2'd3; drain_exp[2] = 2'd0; drain_exp[3] = 2'd1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2 drain valid %0d", k), 32'(rv[0]), 32'd1);
            chk($sformatf("t2 drain data %0d", k), 32'(rd[0]), 32'(drain_exp[k]));
            tick();
        end
        chk("t2 drained", 32'(rv[0]), 32'd0);

        // Settle 3
        do_reset();
        rsp_ready = 1'b0;
        cmd(2'd2, 2'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5 alu_ain hold %0d", k), 32'(aa[1]), 32'd2);
            chk($sformatf("t5 alu_bin hold %0d", k), 32'(bb[1]), 32'd3);
            chk($sformatf("t5 busy %0d", k), 32'(busy[1]), 32'd1);
            chk($sformatf("t5 not ready %0d", k), 32'(rdy[1]), 32'd0);
            chk($sformatf("t5 no rsp yet %0d", k), 32'(rv[1]), 32'd0);
            tick();
        end
        chk("t5 rsp_valid", 32'(rv[1]), 32'd1);
        chk("t5 rsp_data", 32'(rd[1]), 32'd2);
        chk("t5 busy drop", 32'(busy[1]), 32'd0);

        // Reset while issuing with results queued
        do_reset();
        rsp_ready = 1'b0;
        cmd(2'd1, 2'd0, 1'b0);
        tick();
        cmd(2'd2, 2'd0, 1'b0);
        tick();
        cmd(2'd3, 2'd0, 1'b0);
        chk("t6 busy before rst", 32'(busy[0]), 32'd1);
        chk("t6 queued before rst", 32'(rv[0]), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6 rsp_valid", 32'(rv[0]), 32'd0);
        chk("t6 sig_out", 32'(sg[0]), 32'd0);
        chk("t6 busy", 32'(busy[0]), 32'd0);
        chk("t6 alu_ain", 32'(aa[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6 cmd_ready", 32'(rdy[0]), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_ain   = 2'($urandom);
            cmd_bin   = 2'($urandom);
            cmd_sel   = 1'($urandom);
            rsp_ready = ($urandom_range(0, 9) < (i < 1500 ? 3 : 7));
            sig_clear = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; sig_clear = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
